pwm_gen: RTL and testbench

Pulse-width generator that consumes the free-running `count` of the mod-N period counter sitting directly upstream. It compares that count against a duty value to drive a registered PWM output. Duty updates are double-buffered so they only take effect on a period boundary. Start, stop and burst control (a fixed number of periods, then halt) are provided for the motor/LED drive paths.

---
 rtl/pwm_pkg.sv | 13 +
 rtl/duty_shadow.sv | 47 ++++
 rtl/mod_n.sv | 23 ++
 rtl/pwm_gen.sv | 113 +++++++++++
 tb/tb_pwm_gen.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/pwm_pkg.sv
// Shared state codes and count-boundary helper for the PWM generator.
package pwm_pkg;
   localparam logic [1:0] S_IDLE     = 2'd0;
   localparam logic [1:0] S_ARMED    = 2'd1;
   localparam logic [1:0] S_RUN      = 2'd2;
   localparam logic [1:0] S_STOPPING = 2'd3;

   typedef logic [1:0] state_t;

   function automatic logic cnt_eq(input logic [15:0] count, input logic [15:0] target);
      return count == target;
   endfunction
endpackage

// File: rtl/duty_shadow.sv
// Duty shadow (valid/ready, one entry) plus the active duty register.
// Shadow accepts when empty; i_load moves it to active and frees the slot.
module duty_shadow #(
   parameter int DW = 5
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic [DW-1:0] i_duty_data,
   input  logic          i_duty_valid,
   output logic          o_duty_ready,
   input  logic          i_load,
   output logic          o_full,
   output logic [DW-1:0] o_shadow,
   output logic [DW-1:0] o_active
);
   logic          r_full;
   logic          r_ready;
   logic [DW-1:0] r_shadow;
   logic [DW-1:0] r_active;
   logic          w_xfer;
   logic          w_full_nxt;

   assign w_xfer     = i_duty_valid && r_ready;
   // Accept and load never coincide: accept needs empty, load needs full.
   assign w_full_nxt = w_xfer || (r_full && !i_load);

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_full   <= 1'b0;
         r_ready  <= 1'b0;
         r_shadow <= '0;
         r_active <= '0;
      end else begin
         r_full  <= w_full_nxt;
         r_ready <= !w_full_nxt;
         if (w_xfer)
            r_shadow <= i_duty_data;
         if (i_load)
            r_active <= r_shadow;
      end
   end

   assign o_duty_ready = r_ready;
   assign o_full       = r_full;
   assign o_shadow     = r_shadow;
   assign o_active     = r_active;
endmodule

// File: rtl/mod_n.sv
// Free-running mod-N period counter (0..N-1) feeding the PWM compare.
// No latency beyond the register itself; never stalls.
module mod_n #(
   parameter int N     = 12,
   parameter int WIDTH = 4
) (
   input  logic             i_clk,
   input  logic             i_rst,
   output logic [WIDTH-1:0] o_count
);
   logic [WIDTH-1:0] r_count;

   always_ff @(posedge i_clk) begin
      if (!i_rst)
         r_count <= '0;
      else if (r_count == WIDTH'(N - 1))
         r_count <= '0;
      else
         r_count <= r_count + 1'b1;
   end

   assign o_count = r_count;
endmodule

// File: rtl/pwm_gen.sv
// PWM generator: start/stop/burst FSM, period counter and registered duty compare.
// Outputs lag the sampled count by one cycle; duty input backpressured via duty_ready.
module pwm_gen
   import pwm_pkg::*;
#(
   parameter int N      = 12,
   parameter int WIDTH  = 4,
   parameter int BURSTW = 8
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [WIDTH-1:0]  i_count,
   input  logic              i_start,
   input  logic              i_stop,
   input  logic [BURSTW-1:0] i_burst_len,
   input  logic [WIDTH:0]    i_duty_data,
   input  logic              i_duty_valid,
   output logic              o_duty_ready,
   output logic              o_pwm,
   output logic              o_period_start,
   output logic              o_busy,
   output logic              o_done
);
   state_t            r_state;
   state_t            w_state_nxt;
   logic [BURSTW-1:0] r_burst;
   logic [BURSTW-1:0] r_pcnt;
   logic              r_pwm;
   logic              r_pstart;
   logic              r_done;

   logic              w_bnd0;
   logic              w_bndl;
   logic              w_running;
   logic              w_go;
   logic              w_new_period;
   logic              w_last;
   logic              w_done;
   logic              w_accept;
   logic              w_full;
   logic              w_load;
   logic [WIDTH:0]    w_shadow;
   logic [WIDTH:0]    w_active;
   logic [WIDTH:0]    w_duty_eff;
   logic [BURSTW-1:0] w_pcnt_inc;

   assign w_bnd0       = cnt_eq(16'(i_count), 16'd0);
   assign w_bndl       = cnt_eq(16'(i_count), 16'(N - 1));
   assign w_running    = (r_state == S_RUN) || (r_state == S_STOPPING);
   assign w_go         = (r_state == S_ARMED) && w_bnd0 && !i_stop;
   assign w_new_period = w_bnd0 && (w_running || w_go);
   assign w_accept     = (r_state == S_IDLE) && i_start && !i_stop;
   assign w_pcnt_inc   = (&r_pcnt) ? r_pcnt : r_pcnt + 1'b1;
   assign w_last       = (r_state == S_RUN) && (r_burst != '0) && (r_pcnt == r_burst) && w_bndl;
   assign w_done       = w_last || ((r_state == S_STOPPING) && w_bndl);

   // Shadow drains immediately when idle/armed, otherwise only on a period boundary,
   // and the boundary cycle already compares against the freshly loaded value.
   assign w_load     = w_full && (!w_running || w_bnd0);
   assign w_duty_eff = w_load ? w_shadow : w_active;

   duty_shadow #(.DW(WIDTH + 1)) u_shadow (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_duty_data  (i_duty_data),
      .i_duty_valid (i_duty_valid),
      .o_duty_ready (o_duty_ready),
      .i_load       (w_load),
      .o_full       (w_full),
      .o_shadow     (w_shadow),
      .o_active     (w_active)
   );

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:     if (w_accept) w_state_nxt = S_ARMED;
         S_ARMED:    if (i_stop) w_state_nxt = S_IDLE;
                     else if (w_bnd0) w_state_nxt = S_RUN;
         S_RUN:      if (w_last) w_state_nxt = S_IDLE;
                     else if (i_stop) w_state_nxt = S_STOPPING;
         S_STOPPING: if (w_bndl) w_state_nxt = S_IDLE;
         default:    w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_state  <= S_IDLE;
         r_burst  <= '0;
         r_pcnt   <= '0;
         r_pwm    <= 1'b0;
         r_pstart <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_pwm    <= (w_running || w_go) && ((WIDTH + 1)'(i_count) < w_duty_eff);
         r_pstart <= w_new_period;
         r_done   <= w_done;
         if (w_accept) begin
            r_burst <= i_burst_len;
            r_pcnt  <= '0;
         end else if (w_new_period) begin
            r_pcnt  <= w_pcnt_inc;
         end
      end
   end

   assign o_pwm          = r_pwm;
   assign o_period_start = r_pstart;
   assign o_done         = r_done;
   assign o_busy         = (r_state != S_IDLE);
endmodule

// File: tb/tb_pwm_gen.sv
// Bench for pwm_gen driven by the upstream mod_n counter; per-period reference model
// plus directed literal checks, then randomized start/stop/burst/duty traffic.
module tb_pwm_gen;
   localparam int N = 12;

   logic       clk = 1'b0;
   logic       rst;
   logic       start, stop, dval;
   logic [7:0] blen;
   logic [4:0] ddat;
   logic [3:0] count;
   logic       o_duty_ready, o_pwm, o_period_start, o_busy, o_done;

   int n_vec = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   mod_n #(.N(N), .WIDTH(4)) u_cnt (.i_clk(clk), .i_rst(rst), .o_count(count));

   pwm_gen #(.N(N), .WIDTH(4), .BURSTW(8)) dut (
      .i_clk(clk), .i_rst(rst), .i_count(count), .i_start(start), .i_stop(stop),
      .i_burst_len(blen), .i_duty_data(ddat), .i_duty_valid(dval),
      .o_duty_ready(o_duty_ready), .o_pwm(o_pwm), .o_period_start(o_period_start),
      .o_busy(o_busy), .o_done(o_done)
   );

   task automatic chk(input string nm, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: phase 0 idle, 1 waiting for boundary, 2 running, 3 draining.
   // Each period snapshots its duty at its first count; bursts count down periods left.
   int m_ph, m_left, m_duty, m_pend, m_cnt, c_m;
   bit m_finite, m_pend_v, m_ready, live_m, begins_m, xfer_m;
   bit e_pwm, e_ps, e_done;

   always @(posedge clk) begin
      if (!rst) begin
         m_ph = 0; m_left = 0; m_finite = 0; m_duty = 0; m_pend_v = 0;
         m_ready = 0; m_cnt = 0; e_pwm = 0; e_ps = 0; e_done = 0;
      end else begin
         c_m      = m_cnt;
         xfer_m   = dval && m_ready;
         live_m   = (m_ph == 2) || (m_ph == 3);
         begins_m = (c_m == 0) && (live_m || (m_ph == 1 && !stop));
         if (m_pend_v && (!live_m || c_m == 0)) begin
            m_duty   = m_pend;
            m_pend_v = 0;
         end
         e_ps  = begins_m;
         e_pwm = (live_m || begins_m) && (c_m < m_duty);
         if (begins_m && m_finite) m_left--;
         e_done = (c_m == N - 1) && ((m_ph == 2 && m_finite && m_left == 0) || m_ph == 3);
         case (m_ph)
            0: if (start && !stop) begin m_ph = 1; m_finite = (blen != 0); m_left = blen; end
            1: if (stop) m_ph = 0; else if (c_m == 0) m_ph = 2;
            2: if (e_done) m_ph = 0; else if (stop) m_ph = 3;
            default: if (e_done) m_ph = 0;
         endcase
         if (xfer_m) begin m_pend = ddat; m_pend_v = 1; end
         m_ready = !m_pend_v;
         m_cnt   = (c_m == N - 1) ? 0 : c_m + 1;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("pwm", o_pwm, e_pwm);
         chk("period_start", o_period_start, e_ps);
         chk("done", o_done, e_done);
         chk("busy", o_busy, m_ph != 0);
         chk("duty_ready", o_duty_ready, m_ready);
         chk("count", count, m_cnt);
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic send_duty(input int d);
      int n = 0;
      while (!o_duty_ready && n < 40) begin tick(); n++; end
      chk("duty_ready_wait", o_duty_ready, 1);
      dval = 1'b1; ddat = 5'(d);
      tick();
      dval = 1'b0;
   endtask

   task automatic pulse_start(input int bl);
      blen = 8'(bl); start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_count(input int v);
      int n = 0;
      while (count != 4'(v) && n < 30) begin tick(); n++; end
      chk("wait_count", count, v);
   endtask

   task automatic measure_period(input int exp_highs, input string nm);
      int n = 0;
      int highs = 0;
      while (!o_period_start && n < 40) begin tick(); n++; end
      chk({nm, "_pstart_seen"}, o_period_start, 1);
      for (int i = 0; i < N; i++) begin highs += o_pwm; tick(); end
      chk({nm, "_highs"}, highs, exp_highs);
      chk({nm, "_next_pstart"}, o_period_start, 1);
   endtask

   task automatic stop_and_drain();
      int n = 0;
      stop = 1'b1;
      tick();
      stop = 1'b0;
      while (!o_done && n < 30) begin tick(); n++; end
      chk("drain_done_seen", o_done, 1);
   endtask

   initial begin
      int t, ps, highs;
      rst = 1'b0; start = 1'b0; stop = 1'b0; dval = 1'b0; blen = '0; ddat = '0;
      tick();
      chk_en = 1'b1;
      tick(); tick();
      chk("rst_pwm", o_pwm, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_done", o_done, 0);
      chk("rst_pstart", o_period_start, 0);
      chk("rst_ready", o_duty_ready, 0);
      rst = 1'b1;
      tick();
      chk("ready_after_release", o_duty_ready, 1);

      // Continuous run at duty 6.
      send_duty(6);
      pulse_start(0);
      measure_period(6, "duty6");

      // Duty change mid-period applies at the next boundary only.
      wait_count(3);
      send_duty(9);
      chk("ready_low_after_accept", o_duty_ready, 0);
      wait_count(0);
      chk("ready_low_before_bnd0", o_duty_ready, 0);
      tick();
      chk("pstart_at_new_period", o_period_start, 1);
      chk("ready_after_bnd0", o_duty_ready, 1);
      measure_period(9, "duty9");

      // Stop at count 5 completes the period.
      wait_count(5);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      t = 1;
      while (!o_done && t < 30) begin tick(); t++; end
      chk("stop_done_gap", t, 7);
      chk("stop_busy_low", o_busy, 0);
      highs = 0;
      for (int i = 0; i < 24; i++) begin highs += o_pwm; tick(); end
      chk("idle_no_pwm", highs, 0);

      // Burst of 3 periods at duty 4.
      send_duty(4);
      pulse_start(3);
      t = 0; ps = 0; highs = 0;
      while (!o_done && t < 100) begin ps += o_period_start; highs += o_pwm; tick(); t++; end
      chk("burst_done_seen", o_done, 1);
      chk("burst_periods", ps, 3);
      chk("burst_highs", highs, 12);
      chk("burst_busy_low", o_busy, 0);
      chk("burst_done_count", count, 0);

      // Duty 0 then duty 12 saturate.
      send_duty(0);
      pulse_start(0);
      measure_period(0, "duty0");
      wait_count(3);
      send_duty(12);
      measure_period(12, "duty12");
      stop_and_drain();

      // Mid-run reset, then clean restart.
      pulse_start(0);
      t = 0;
      while (!o_pwm && t < 40) begin tick(); t++; end
      chk("pwm_high_before_rst", o_pwm, 1);
      tick();
      rst = 1'b0;
      tick();
      chk("midrst_pwm", o_pwm, 0);
      chk("midrst_busy", o_busy, 0);
      chk("midrst_ready", o_duty_ready, 0);
      rst = 1'b1;
      tick();
      send_duty(6);
      pulse_start(0);
      measure_period(6, "restart_duty6");
      stop_and_drain();

      // Randomized traffic against the model.
      for (int i = 0; i < 4000; i++) begin
         start = ($urandom % 16) == 0;
         stop  = ($urandom % 40) == 0;
         blen  = 8'($urandom_range(0, 4));
         dval  = ($urandom % 3) == 0;
         ddat  = 5'($urandom_range(0, N));
         rst   = ($urandom % 500) != 0;
         tick();
      end
      start = 1'b0; stop = 1'b0; dval = 1'b0; rst = 1'b1;
      tick(); tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
